// File: rtl/vvm_seq_pkg.sv
// Shared types and constants for the vvm sequencer: FSM state encoding,
// the default engine window count, and an elaboration-time length check.
package vvm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_B = 3'd1,
    S_LD_B = 3'd2,
    S_LD_A = 3'd3,
    S_WAIT = 3'd4,
    S_OUT  = 3'd5,
    S_RD_A = 3'd6
  } state_t;

  localparam int L_DEFAULT = 176;
  localparam int W_DEFAULT = 4;
  localparam int WL        = L_DEFAULT / W_DEFAULT;

  // The engine walks the vector in whole windows, so L must split evenly.
  function automatic bit len_ok(input int l, input int w);
    return (w > 0) && ((l % w) == 0);
  endfunction

endpackage

// File: rtl/vvm_seq.sv
// Matrix-vector sequencer for the vvm MAC engine: fetches the vector once,
// then one matrix row per pass, and streams one dot product per row.
module vvm_seq
  import vvm_seq_pkg::*;
#(
  parameter int L  = 176,
  parameter int W  = 4,
  parameter int Q  = 8,
  parameter int DQ = 18,
  parameter int AW = 10,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_vaddr,
  input  logic [AW-1:0] cmd_base,
  input  logic [RW-1:0] cmd_rows,
  input  logic [Q-1:0]  cmd_zA,
  input  logic [Q-1:0]  cmd_zB,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic          vvm_A_ld,
  output logic          vvm_B_ld,
  output logic          vvm_start,
  output logic [Q-1:0]  vvm_zA,
  output logic [Q-1:0]  vvm_zB,
  input  logic          vvm_rdy,
  input  logic [DQ-1:0] vvm_C,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DQ-1:0] res_data,
  output logic [RW-1:0] res_idx,
  output logic          res_last,
  output logic          busy,
  output logic          done
);

  if (!len_ok(L, W)) begin : g_len_chk
    $error("vvm_seq: L must be a multiple of W");
  end

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] vaddr_q;
  logic [AW-1:0] base_q;
  logic [RW-1:0] rows_q;
  logic [RW-1:0] r_q;
  logic          done_q;
  logic          cmd_fire;
  logic          res_fire;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // while valid is high and ready low, the source holds its payload stable.
  assign cmd_ready = (state == S_IDLE);
  assign cmd_fire  = cmd_ready & cmd_valid;
  assign res_valid = (state == S_OUT);
  assign res_fire  = res_valid & res_ready;
  assign busy      = (state != S_IDLE);
  assign done      = done_q | (res_fire & res_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    mem_rd_en = 1'b0;
    mem_addr  = base_q + AW'(r_q);
    vvm_A_ld  = 1'b0;
    vvm_B_ld  = 1'b0;
    vvm_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && (cmd_rows != '0)) state_n = S_RD_B;
      end
      S_RD_B: begin
        mem_rd_en = 1'b1;
        mem_addr  = vaddr_q;
        state_n   = S_LD_B;
      end
      S_LD_B: begin
        vvm_B_ld  = 1'b1;
        mem_rd_en = 1'b1;
        state_n   = S_LD_A;
      end
      // Row fetch for every row after the first; the vector is already loaded.
      S_RD_A: begin
        mem_rd_en = 1'b1;
        state_n   = S_LD_A;
      end
      // Start with the load: the engine first indexes A a cycle later.
      S_LD_A: begin
        vvm_A_ld  = 1'b1;
        vvm_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (vvm_rdy) state_n = S_OUT;
      end
      S_OUT: begin
        if (res_ready) state_n = res_last ? S_IDLE : S_RD_A;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q  <= '0;
      base_q   <= '0;
      rows_q   <= '0;
      r_q      <= '0;
      vvm_zA   <= '0;
      vvm_zB   <= '0;
      res_data <= '0;
      res_idx  <= '0;
      res_last <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cmd_fire) begin
        vaddr_q <= cmd_vaddr;
        base_q  <= cmd_base;
        rows_q  <= cmd_rows;
        vvm_zA  <= cmd_zA;
        vvm_zB  <= cmd_zB;
        r_q     <= '0;
        done_q  <= (cmd_rows == '0);
      end
      if ((state == S_WAIT) && vvm_rdy) begin
        res_data <= vvm_C;
        res_idx  <= r_q;
        res_last <= (r_q == (rows_q - RW'(1)));
      end
      if (res_fire && !res_last) begin
        r_q <= r_q + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vvm_seq.sv
// Bench for vvm_seq: models the row memory and the vvm engine around the
// sequencer and scores each streamed result against an arithmetic reference.
module tb_vvm_seq;

  localparam int L  = 176;
  localparam int W  = 4;
  localparam int Q  = 8;
  localparam int DQ = 18;
  localparam int AW = 10;
  localparam int RW = 8;
  localparam int WL = L / W;
  localparam int NA = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_vaddr;
  logic [AW-1:0] cmd_base;
  logic [RW-1:0] cmd_rows;
  logic [Q-1:0]  cmd_zA;
  logic [Q-1:0]  cmd_zB;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          vvm_A_ld;
  logic          vvm_B_ld;
  logic          vvm_start;
  logic [Q-1:0]  vvm_zA;
  logic [Q-1:0]  vvm_zB;
  logic          vvm_rdy;
  logic [DQ-1:0] vvm_C;
  logic          res_valid;
  logic          res_ready;
  logic [DQ-1:0] res_data;
  logic [RW-1:0] res_idx;
  logic          res_last;
  logic          busy;
  logic          done;

  vvm_seq #(.L(L), .W(W), .Q(Q), .DQ(DQ), .AW(AW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vaddr(cmd_vaddr),
    .cmd_base(cmd_base), .cmd_rows(cmd_rows), .cmd_zA(cmd_zA), .cmd_zB(cmd_zB),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .vvm_A_ld(vvm_A_ld), .vvm_B_ld(vvm_B_ld), .vvm_start(vvm_start),
    .vvm_zA(vvm_zA), .vvm_zB(vvm_zB), .vvm_rdy(vvm_rdy), .vvm_C(vvm_C),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done)
  );

  // ---------------- environment: row memory + engine ----------------
  logic signed [Q-1:0] mem [NA][L];
  logic signed [Q-1:0] bus [L];
  logic signed [Q-1:0] vb  [L];
  int            eng_cnt;
  logic [DQ-1:0] eng_res;
  logic [DQ-1:0] eng_pend;

  always @(posedge clk) begin
    if (mem_rd_en) for (int i = 0; i < L; i++) bus[i] <= mem[mem_addr][i];
  end

  function automatic logic [DQ-1:0] eng_dot();
    int s = 0;
    for (int i = 0; i < L; i++)
      s += (int'(bus[i]) - int'($signed(vvm_zA))) * (int'(vb[i]) - int'($signed(vvm_zB)));
    return DQ'(s);
  endfunction

  // Engine: busy for WL cycles after start, accumulator valid when ready returns.
  assign vvm_rdy = (eng_cnt == 0);
  assign vvm_C   = eng_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt  <= 0;
      eng_res  <= '0;
      eng_pend <= '0;
    end else begin
      if (vvm_B_ld) for (int j = 0; j < L; j++) vb[j] <= bus[j];
      if (vvm_start) begin
        eng_cnt  <= WL;
        eng_res  <= '0;
        eng_pend <= eng_dot();
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) eng_res <= eng_pend;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  function automatic logic [DQ-1:0] ref_dot(input int va, input int ra,
                                            input logic signed [Q-1:0] za,
                                            input logic signed [Q-1:0] zb);
    int s = 0;
    for (int i = 0; i < L; i++)
      s += (int'(mem[ra][i]) - int'(za)) * (int'(mem[va][i]) - int'(zb));
    return DQ'(s);
  endfunction

  logic [DQ-1:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fill_row(input int a, input int v);
    for (int i = 0; i < L; i++) mem[a % NA][i] = Q'(v);
  endtask

  // ---------------- driver: one command, fully scored ----------------
  task automatic run_cmd(input int va, input int ba, input int nr, input int za, input int zb,
                         input int hold_row, input int hold_cyc);
    int t0, k, rdn, waited, valid_at, fetch_at, budget;
    logic [DQ-1:0] held;
    logic [AW-1:0] ea;
    logic [Q-1:0]  zap, zbp;
    bit seen, fin, zp_ok, bp_ok, done_ok, busy_ok;
    zap = Q'(za); zbp = Q'(zb);
    k = 0; rdn = 0; waited = 0; fetch_at = -1; budget = 0; held = '0;
    seen = 0; fin = 0; zp_ok = 1; bp_ok = 1; done_ok = 1; busy_ok = 1;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_vaddr = AW'(va); cmd_base = AW'(ba); cmd_rows = RW'(nr);
    cmd_zA = zap; cmd_zB = zbp; cmd_valid = 1'b1;
    t0 = cyc;
    valid_at = t0 + WL + 5;
    while (!fin && budget < 4000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      budget++;
      res_ready = 1'b1;
      if (res_valid && k == hold_row && waited < hold_cyc) begin
        res_ready = 1'b0;
        waited++;
      end
      #1;
      if (vvm_zA !== zap || vvm_zB !== zbp) zp_ok = 0;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_ok = 0;
      if (cyc == fetch_at) chk("fetch_after_hs", 32'(mem_rd_en), 32'd1);
      if (mem_rd_en) begin
        ea = (rdn == 0) ? AW'(va) : AW'(ba + rdn - 1);
        chk("rd_addr", 32'(mem_addr), 32'(ea));
        rdn++;
        if (res_valid) bp_ok = 0;
      end
      if (res_valid) begin
        if (!seen) begin
          chk("res_time", 32'(cyc - t0), 32'(valid_at - t0));
          seen = 1;
          held = res_data;
        end else if (res_data !== held) begin
          bp_ok = 0;
        end
        if (res_ready) begin
          chk("res_data", 32'(res_data), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
          chk("res_idx", 32'(res_idx), 32'(k));
          chk("res_last", 32'(res_last), 32'(k == nr - 1));
          chk("done_hs", 32'(done), 32'(k == nr - 1));
          if (k == nr - 1) begin
            fin = 1;
          end else begin
            k++;
            seen = 0;
            valid_at = cyc + WL + 4;
            fetch_at = cyc + 1;
          end
        end else if (done) begin
          done_ok = 0;
        end
      end else if (done) begin
        done_ok = 0;
      end
    end
    chk("cmd_complete", 32'(fin), 32'd1);
    chk("rd_count", 32'(rdn), 32'(nr + 1));
    chk("zp_stable", 32'(zp_ok), 32'd1);
    chk("out_hold", 32'(bp_ok), 32'd1);
    chk("done_only_end", 32'(done_ok), 32'd1);
    chk("busy_during", 32'(busy_ok), 32'd1);
    @(negedge clk);
    #1;
    chk("idle_after", 32'({cmd_ready, busy, done, res_valid, mem_rd_en}), 32'b10000);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int vaddr; int base; int rows; int za; int zb;
    int vec_val; int row_val0; int row_step;
    int hold_row; int hold_cyc;
    int exp_first; int exp_step;
  } vec_t;

  vec_t tbl [4];

  initial begin
    global_watchdog();
  end

  task automatic global_watchdog();
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  endtask

  initial begin
    int b;
    bit ok;
    cmd_valid = 0; cmd_vaddr = '0; cmd_base = '0; cmd_rows = '0;
    cmd_zA = '0; cmd_zB = '0; res_ready = 1'b1;

    tbl[0] = '{10,    20,     1, 0,  0, 1, 1, 0, -1,  0,  176,   0};
    tbl[1] = '{5,     'h3FF,  3, 0,  0, 1, 1, 1, -1,  0,  176, 176};
    tbl[2] = '{7,     'h100,  3, 1, -2, 1, 1, 0, -1,  0,    0,   0};
    tbl[3] = '{30,    'h40,   2, 0,  0, 2, 3, 1,  0, 20, 1056, 352};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_ctrl", 32'({busy, done, res_valid, res_last, mem_rd_en, vvm_A_ld, vvm_B_ld, vvm_start}), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_idx", 32'(res_idx), 32'd0);
    chk("rst_zp", 32'({vvm_zA, vvm_zB}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      fill_row(tbl[t].vaddr, tbl[t].vec_val);
      for (int k = 0; k < tbl[t].rows; k++) begin
        fill_row(tbl[t].base + k, tbl[t].row_val0 + k * tbl[t].row_step);
        exp_q.push_back(DQ'(tbl[t].exp_first + k * tbl[t].exp_step));
      end
      run_cmd(tbl[t].vaddr, tbl[t].base, tbl[t].rows, tbl[t].za, tbl[t].zb,
              tbl[t].hold_row, tbl[t].hold_cyc);
    end

    // rows == 0: done next cycle, nothing else happens
    @(negedge clk);
    cmd_vaddr = AW'(3); cmd_base = AW'(9); cmd_rows = '0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_quiet_first", 32'({mem_rd_en, res_valid, busy}), 32'd0);
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done || mem_rd_en || res_valid || busy) ok = 0;
    end
    chk("zero_quiet", 32'(ok), 32'd1);

    // reset while waiting on row 1
    fill_row('h200, 1);
    for (int k = 0; k < 3; k++) fill_row('h210 + k, 1);
    @(negedge clk);
    cmd_vaddr = AW'('h200); cmd_base = AW'('h210); cmd_rows = RW'(3);
    cmd_zA = '0; cmd_zB = '0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    b = 0;
    while (!res_valid && b < 200) begin @(negedge clk); b++; end
    chk("mid_row0_seen", 32'(res_valid), 32'd1);
    @(negedge clk);
    b = 0;
    while (!mem_rd_en && b < 10) begin @(negedge clk); b++; end
    chk("mid_row1_fetch", 32'(mem_rd_en), 32'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("mid_in_wait", 32'({busy, res_valid, mem_rd_en}), 32'b100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({cmd_ready, busy, done, res_valid, res_last, mem_rd_en, vvm_A_ld, vvm_B_ld, vvm_start}),
        32'b100000000);
    chk("mid_rst_res", 32'({res_data, res_idx}), 32'd0);
    chk("mid_rst_zp", 32'({vvm_zA, vvm_zB}), 32'd0);
    @(posedge clk);
    #2;
    chk("mid_rst_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    fill_row('h220, 3);
    for (int k = 0; k < 2; k++) begin
      fill_row('h230 + k, 2);
      exp_q.push_back(DQ'(1056));
    end
    run_cmd('h220, 'h230, 2, 0, 0, -1, 0);

    // randomized commands against the arithmetic reference
    for (int n = 0; n < 6; n++) begin
      int va, ba, nr, za, zb;
      va = $urandom_range(0, NA - 1);
      ba = $urandom_range(0, NA - 1);
      nr = $urandom_range(1, 3);
      za = $urandom_range(0, 255);
      zb = $urandom_range(0, 255);
      for (int k = 0; k < nr; k++)
        if (((ba + k) % NA) == va) va = (va + NA / 2) % NA;
      for (int i = 0; i < L; i++) mem[va][i] = Q'($urandom_range(0, 255));
      for (int k = 0; k < nr; k++) begin
        for (int i = 0; i < L; i++) mem[(ba + k) % NA][i] = Q'($urandom_range(0, 255));
        exp_q.push_back(ref_dot(va, (ba + k) % NA, Q'(za), Q'(zb)));
      end
      run_cmd(va, ba, nr, za, zb, $urandom_range(0, nr - 1), $urandom_range(0, 6));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
